// File: rtl/lq_agen_pkg.sv
// Shared generate/transmit types and the lookahead merge used by the LQ AGEN trees.
package lq_agen_pkg;

  typedef struct packed {
    logic g;
    logic t;
  } gt_t;

  // hi is the more significant span; a carry out of lo passes through hi when t_hi is set
  function automatic gt_t gt_merge(input logic g_hi, input logic t_hi,
                                   input logic g_lo, input logic t_lo);
    gt_t r;
    r.g = g_hi | (t_hi & g_lo);
    r.t = t_hi & t_lo;
    return r;
  endfunction

endpackage

// File: rtl/lq_agen_gtgrp.sv
// Combinational group generate/transmit tree over GRP active-low bits (bit 0 = MSB).
module lq_agen_gtgrp
  import lq_agen_pkg::*;
#(
  parameter int unsigned GRP = 8
) (
  input  logic [0:GRP-1] x_b,
  input  logic [0:GRP-1] y_b,
  output logic           g,
  output logic           t
);

  localparam int unsigned LVLS = $clog2(GRP);

  logic [0:GRP-1] g_w;
  logic [0:GRP-1] t_w;
  gt_t            m;

  // In-place radix-2 reduction: at each level slot j absorbs slot j+span, so slot 0 ends up covering the group.
  always_comb begin
    g_w = ~x_b & ~y_b;
    t_w = ~x_b | ~y_b;
    m   = '0;
    for (int unsigned lvl = 0; lvl < LVLS; lvl++) begin
      for (int unsigned j = 0; j < GRP; j++) begin
        if ((j % (32'd2 << lvl)) == 32'd0) begin
          m = gt_merge(g_w[j], t_w[j],
                       g_w[(j + (32'd1 << lvl)) % GRP], t_w[(j + (32'd1 << lvl)) % GRP]);
          g_w[j] = m.g;
          t_w[j] = m.t;
        end
      end
    end
    g = g_w[0];
    t = t_w[0];
  end

endmodule

// File: rtl/lq_agen_glbloc_pipe.sv
// Two-stage pipelined group lookahead tree for the LQ AGEN adder with valid/ready, stall and flush.
module lq_agen_glbloc_pipe
  import lq_agen_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned GRP   = 8,
  parameter int unsigned TAGW  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:WIDTH-1]       x_b,
  input  logic [0:WIDTH-1]       y_b,
  input  logic                   ci,
  input  logic [0:TAGW-1]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:WIDTH/GRP-1]   g_grp,
  output logic [0:WIDTH/GRP-1]   t_grp,
  output logic [0:WIDTH/GRP-1]   c_grp,
  output logic                   g_all,
  output logic                   t_all,
  output logic                   co,
  output logic [0:TAGW-1]        out_tag
);

  localparam int unsigned NG = WIDTH / GRP;

  logic [0:NG-1]   g_grp_c, t_grp_c;
  logic            adv1, adv2, push, load2;

  logic            v1_q, v1_d, v2_q, v2_d;
  logic [0:NG-1]   g1_q, g1_d, t1_q, t1_d;
  logic            ci1_q, ci1_d;
  logic [0:TAGW-1] tag1_q, tag1_d;

  logic [0:NG-1]   c_s2;
  gt_t             all_s2;

  logic [0:NG-1]   g2_q, g2_d, t2_q, t2_d, c2_q, c2_d;
  logic            gall2_q, gall2_d, tall2_q, tall2_d, co2_q, co2_d;
  logic [0:TAGW-1] tag2_q, tag2_d;

  for (genvar k = 0; k < NG; k++) begin : g_tree
    lq_agen_gtgrp #(.GRP(GRP)) u_gtgrp (
      .x_b (x_b[k*GRP +: GRP]),
      .y_b (y_b[k*GRP +: GRP]),
      .g   (g_grp_c[k]),
      .t   (t_grp_c[k])
    );
  end

  // in_ready is forced during rst so upstream never sees a stall while the pipe is being cleared
  always_comb begin
    adv2     = ~v2_q | out_ready;
    adv1     = ~v1_q | adv2;
    in_ready = adv1 | rst;
    push     = in_valid & adv1 & ~flush;
    load2    = adv2 & v1_q & ~flush;
  end

  // Carry ripples from the LSB group (NG-1) toward group 0; the global g/t fold follows the same order.
  always_comb begin
    c_s2         = '0;
    c_s2[NG-1]   = ci1_q;
    all_s2.g     = g1_q[NG-1];
    all_s2.t     = t1_q[NG-1];
    for (int unsigned i = 1; i < NG; i++) begin
      c_s2[NG-1-i] = g1_q[NG-i] | (t1_q[NG-i] & c_s2[NG-i]);
      all_s2       = gt_merge(g1_q[NG-1-i], t1_q[NG-1-i], all_s2.g, all_s2.t);
    end
  end

  always_comb begin
    v1_d   = adv1 ? push : v1_q;
    v2_d   = adv2 ? v1_q : v2_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
    g1_d   = push ? g_grp_c : g1_q;
    t1_d   = push ? t_grp_c : t1_q;
    ci1_d  = push ? ci      : ci1_q;
    tag1_d = push ? in_tag  : tag1_q;

    g2_d    = load2 ? g1_q                           : g2_q;
    t2_d    = load2 ? t1_q                           : t2_q;
    c2_d    = load2 ? c_s2                           : c2_q;
    gall2_d = load2 ? all_s2.g                       : gall2_q;
    tall2_d = load2 ? all_s2.t                       : tall2_q;
    co2_d   = load2 ? (all_s2.g | (all_s2.t & ci1_q)) : co2_q;
    tag2_d  = load2 ? tag1_q                         : tag2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      g1_q    <= '0;
      t1_q    <= '0;
      ci1_q   <= 1'b0;
      tag1_q  <= '0;
      g2_q    <= '0;
      t2_q    <= '0;
      c2_q    <= '0;
      gall2_q <= 1'b0;
      tall2_q <= 1'b0;
      co2_q   <= 1'b0;
      tag2_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      g1_q    <= g1_d;
      t1_q    <= t1_d;
      ci1_q   <= ci1_d;
      tag1_q  <= tag1_d;
      g2_q    <= g2_d;
      t2_q    <= t2_d;
      c2_q    <= c2_d;
      gall2_q <= gall2_d;
      tall2_q <= tall2_d;
      co2_q   <= co2_d;
      tag2_q  <= tag2_d;
    end
  end

  assign out_valid = v2_q;
  assign g_grp     = g2_q;
  assign t_grp     = t2_q;
  assign c_grp     = c2_q;
  assign g_all     = gall2_q;
  assign t_all     = tall2_q;
  assign co        = co2_q;
  assign out_tag   = tag2_q;

endmodule

// File: tb/tb_lq_agen_glbloc_pipe.sv
// Bench for lq_agen_glbloc_pipe: three widths driven in lockstep, checked against an arithmetic reference.
module tb_lq_agen_glbloc_pipe;

  logic        clk, rst, flush, in_valid, out_ready, ci;
  logic [63:0] x, y;
  logic [5:0]  tag;
  logic [63:0] xb, yb;

  assign xb = ~x;
  assign yb = ~y;

  logic       ir64, ov64, ga64, ta64, co64;
  logic [7:0] g64, t64, c64;
  logic [5:0] tag64;
  logic       ir32, ov32, ga32, ta32, co32;
  logic [7:0] g32, t32, c32;
  logic [5:0] tag32;
  logic       ir16, ov16, ga16, ta16, co16;
  logic       g16, t16, c16;
  logic [5:0] tag16;

  lq_agen_glbloc_pipe #(.WIDTH(64), .GRP(8), .TAGW(6)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .x_b(xb), .y_b(yb), .ci(ci), .in_tag(tag), .out_valid(ov64), .out_ready(out_ready),
    .g_grp(g64), .t_grp(t64), .c_grp(c64), .g_all(ga64), .t_all(ta64), .co(co64), .out_tag(tag64));

  lq_agen_glbloc_pipe #(.WIDTH(32), .GRP(4), .TAGW(6)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .x_b(xb[31:0]), .y_b(yb[31:0]), .ci(ci), .in_tag(tag), .out_valid(ov32), .out_ready(out_ready),
    .g_grp(g32), .t_grp(t32), .c_grp(c32), .g_all(ga32), .t_all(ta32), .co(co32), .out_tag(tag32));

  lq_agen_glbloc_pipe #(.WIDTH(16), .GRP(16), .TAGW(6)) u16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir16),
    .x_b(xb[15:0]), .y_b(yb[15:0]), .ci(ci), .in_tag(tag), .out_valid(ov16), .out_ready(out_ready),
    .g_grp(g16), .t_grp(t16), .c_grp(c16), .g_all(ga16), .t_all(ta16), .co(co16), .out_tag(tag16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: group/carry values from plain integer addition over the numeric (LSB-0) operands.
  function automatic void ref_calc(input int unsigned w, input int unsigned gs,
                                   input logic [63:0] a, input logic [63:0] b, input logic cin,
                                   output logic [7:0] eg, output logic [7:0] et, output logic [7:0] ec,
                                   output logic ega, output logic eta, output logic eco);
    logic [64:0] aw, bw, wm, gm, lm, s;
    int unsigned ng;
    ng = w / gs;
    wm = (65'd1 << w) - 65'd1;
    gm = (65'd1 << gs) - 65'd1;
    aw = {1'b0, a} & wm;
    bw = {1'b0, b} & wm;
    eg = '0; et = '0; ec = '0;
    for (int unsigned k = 0; k < ng; k++) begin
      lm = (65'd1 << (k*gs)) - 65'd1;
      s = (aw & lm) + (bw & lm) + {64'd0, cin};
      ec[k] = s[k*gs];
      s = ((aw >> (k*gs)) & gm) + ((bw >> (k*gs)) & gm);
      eg[k] = s[gs];
      et[k] = ((((aw | bw) >> (k*gs)) & gm) == gm);
    end
    s = aw + bw;
    ega = s[w];
    eta = ((aw | bw) == wm);
    s = aw + bw + {64'd0, cin};
    eco = s[w];
  endfunction

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [5:0]  tg;
    int unsigned age;
  } op_t;

  op_t q[$];

  // An op is at the output once it has seen at least one edge after acceptance; anything else in flight sits in stage 1.
  function automatic bit m_v2();
    return (q.size() >= 1) && (q[0].age >= 1);
  endfunction
  function automatic bit m_v1();
    return (q.size() == 2) || ((q.size() == 1) && (q[0].age == 0));
  endfunction

  always @(posedge clk) begin
    bit v1, v2, ir;
    op_t e;
    v1 = m_v1();
    v2 = m_v2();
    ir = !v1 || !v2 || out_ready;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (v2 && out_ready) begin
        void'(q.pop_front());
        pop_cnt++;
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.age++;
        q[i] = e;
      end
      if (in_valid && ir) begin
        e.a = x; e.b = y; e.c = ci; e.tg = tag; e.age = 0;
        q.push_back(e);
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    bit ev2;
    logic exp_ir;
    logic [7:0] eg, et, ec;
    logic ega, eta, eco;
    ev2 = m_v2();
    exp_ir = rst | !m_v1() | !ev2 | out_ready;
    chk("in_ready64", ir64, exp_ir);
    chk("in_ready32", ir32, exp_ir);
    chk("in_ready16", ir16, exp_ir);
    chk("out_valid64", ov64, ev2);
    chk("out_valid32", ov32, ev2);
    chk("out_valid16", ov16, ev2);
    if (ev2) begin
      ref_calc(64, 8, q[0].a, q[0].b, q[0].c, eg, et, ec, ega, eta, eco);
      chk("g_grp64", g64, eg); chk("t_grp64", t64, et); chk("c_grp64", c64, ec);
      chk("g_all64", ga64, ega); chk("t_all64", ta64, eta); chk("co64", co64, eco);
      chk("tag64", tag64, q[0].tg);
      ref_calc(32, 4, q[0].a, q[0].b, q[0].c, eg, et, ec, ega, eta, eco);
      chk("g_grp32", g32, eg); chk("t_grp32", t32, et); chk("c_grp32", c32, ec);
      chk("g_all32", ga32, ega); chk("t_all32", ta32, eta); chk("co32", co32, eco);
      chk("tag32", tag32, q[0].tg);
      ref_calc(16, 16, q[0].a, q[0].b, q[0].c, eg, et, ec, ega, eta, eco);
      chk("g_grp16", g16, eg[0]); chk("t_grp16", t16, et[0]); chk("c_grp16", c16, ec[0]);
      chk("g_all16", ga16, ega); chk("t_all16", ta16, eta); chk("co16", co16, eco);
      chk("tag16", tag16, q[0].tg);
    end
  end

  task automatic load(input logic [5:0] tg);
    x   = {$urandom, $urandom};
    y   = {$urandom, $urandom};
    ci  = 1'($urandom_range(0, 1));
    tag = tg;
  endtask

  initial begin
    int vcnt, first, last, acc0, prev, pops0, found;
    logic [5:0] ftag;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; ci = 1'b0; tag = '0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", ov64, 0);
    chk("rst_in_ready", ir64, 1);
    chk("rst_g_grp", g64, 0);
    chk("rst_tag", tag64, 0);

    // Case 1: 0xFF + 1
    #1 rst = 1'b0;
    x = 64'h0000_0000_0000_00FF; y = 64'h1; ci = 1'b0; tag = 6'd1; in_valid = 1'b1;
    @(negedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("c1_valid", ov64, 1);
    chk("c1_g64", g64, 8'h01); chk("c1_t64", t64, 8'h01); chk("c1_c64", c64, 8'h02);
    chk("c1_co64", co64, 0);   chk("c1_gall64", ga64, 0); chk("c1_tall64", ta64, 0);
    chk("c1_g32", g32, 8'h01); chk("c1_t32", t32, 8'h03); chk("c1_c32", c32, 8'h06);
    chk("c1_co32", co32, 0);
    chk("c1_g16", g16, 0); chk("c1_t16", t16, 0); chk("c1_c16", c16, 0); chk("c1_co16", co16, 0);

    // Case 2: all-ones + 0 + carry-in
    #1 x = '1; y = '0; ci = 1'b1; tag = 6'd2; in_valid = 1'b1;
    @(negedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("c2_t_all64", ta64, 1); chk("c2_g_all64", ga64, 0); chk("c2_c64", c64, 8'hFF);
    chk("c2_co64", co64, 1);    chk("c2_t64", t64, 8'hFF);  chk("c2_g64", g64, 8'h00);
    chk("c2_t_all32", ta32, 1); chk("c2_c32", c32, 8'hFF);  chk("c2_co32", co32, 1);
    chk("c2_t_all16", ta16, 1); chk("c2_c16", c16, 1);      chk("c2_co16", co16, 1);
    chk("c2_tag", tag64, 6'd2);

    // Case 3: back-to-back stream of 10
    vcnt = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (ov64) begin
        vcnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      #1;
      if (cyc < 10) begin
        load(6'(10 + cyc));
        in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    chk("c3_valid_count", 64'(vcnt), 10);
    chk("c3_contiguous", 64'(last - first), 9);
    chk("c3_first_latency", 64'(first), 2);

    // Case 4: stall with both stages full
    out_ready = 1'b0; acc0 = acc_cnt; prev = acc_cnt;
    load(6'd20); in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (acc_cnt != prev) begin
        prev = acc_cnt;
        load(6'(20 + acc_cnt - acc0));
      end
    end
    chk("c4_accepts", 64'(acc_cnt - acc0), 2);
    chk("c4_in_ready", ir64, 0);
    chk("c4_out_valid", ov64, 1);
    out_ready = 1'b1; in_valid = 1'b0; pops0 = pop_cnt;
    repeat (4) @(negedge clk);
    chk("c4_drained", 64'(pop_cnt - pops0), 2);
    chk("c4_empty", ov64, 0);

    // Case 5: flush with both stages full
    #1 out_ready = 1'b0; load(6'd30); in_valid = 1'b1;
    @(negedge clk); #1 load(6'd31);
    @(negedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("c5_full_valid", ov64, 1);
    chk("c5_full_ready", ir64, 0);
    #1 flush = 1'b1; load(6'd45); in_valid = 1'b1;
    @(negedge clk);
    chk("c5_flushed", ov64, 0);
    #1 flush = 1'b0; out_ready = 1'b1; load(6'd40); in_valid = 1'b1;
    found = -1; ftag = '0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (ov64 && found < 0) begin
        found = n;
        ftag = tag64;
      end
      #1 in_valid = 1'b0;
    end
    chk("c5_latency", 64'(found), 2);
    chk("c5_tag", ftag, 6'd40);

    // Case 6: reset with both stages full
    out_ready = 1'b0; load(6'd50); in_valid = 1'b1;
    @(negedge clk); #1 load(6'd51);
    @(negedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("c6_full_valid", ov64, 1);
    chk("c6_full_ready", ir64, 0);
    #1 rst = 1'b1;
    #1 chk("c6_ready_during_rst", ir64, 1);
    @(negedge clk);
    chk("c6_out_valid", ov64, 0);
    chk("c6_g_grp", g64, 0); chk("c6_c_grp", c64, 0); chk("c6_co", co64, 0);
    chk("c6_tag", tag64, 0); chk("c6_g_grp32", g32, 0); chk("c6_t_grp16", t16, 0);
    chk("c6_in_ready", ir64, 1);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("c6_after_ready", ir64, 1);
    chk("c6_after_valid", ov64, 0);

    // Short mixed stream with random back-pressure after reset
    #1 prev = acc_cnt; load(6'd60); in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      if (acc_cnt != prev) begin
        prev = acc_cnt;
        if (acc_cnt - acc0 < 40) load(6'(acc_cnt)); else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("final_empty", ov64, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
